unidade_controle_rodadas: RTL

- Moore control unit for the round-based sequence-memory game.
- Drives the game datapath's counters, register and timeout counter, and consumes its status flags.
- Runs rounds of increasing length: round k requires k+1 correct plays.
- Ends in one of three terminal outcomes: success, wrong play, or timeout.

---
 rtl/unidade_controle_rodadas_if.sv | 38 +++
 rtl/unidade_controle_rodadas.sv | 111 +++++++++++
 2 files changed

// File: rtl/unidade_controle_rodadas_if.sv
// Handshake between the round controller and the game datapath:
// status flags in, counter/register controls and debug state code out.
`default_nettype none

interface unidade_controle_rodadas_if;
    logic       iniciar;
    logic       jogada_feita;
    logic       igual;
    logic       fimRodada;
    logic       fimL;
    logic       fimT;
    logic       zeraL;
    logic       contaCL;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       conta;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada_feita, igual, fimRodada, fimL, fimT,
        output zeraL, contaCL, zeraC, contaC, zeraR, registraR, conta,
               pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        output iniciar, jogada_feita, igual, fimRodada, fimL, fimT,
        input  zeraL, contaCL, zeraC, contaC, zeraR, registraR, conta,
               pronto, acertou, errou, timeout, db_estado
    );
endinterface

`default_nettype wire

// File: rtl/unidade_controle_rodadas.sv
// Moore controller for the round-based sequence-memory game; round k needs
// k+1 correct plays and the game ends in success, wrong play or timeout.
`default_nettype none

module unidade_controle_rodadas (
    input  logic                              clock,
    input  logic                              reset,
    unidade_controle_rodadas_if.master        ctrl
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARA        = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE
    } estado_t;

    estado_t estado_q;
    estado_t estado_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:        estado_d = ctrl.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     estado_d = INICIA_RODADA;
            INICIA_RODADA:  estado_d = ESPERA_JOGADA;
            // A play arriving together with the timeout still counts
            ESPERA_JOGADA: begin
                if (ctrl.jogada_feita)   estado_d = REGISTRA;
                else if (ctrl.fimT)      estado_d = FIM_TIMEOUT;
                else                     estado_d = ESPERA_JOGADA;
            end
            REGISTRA:       estado_d = COMPARA;
            COMPARA: begin
                if (!ctrl.igual)                        estado_d = FIM_ERROU;
                else if (ctrl.fimRodada && ctrl.fimL)   estado_d = FIM_ACERTOU;
                else if (ctrl.fimRodada)                estado_d = PROXIMA_RODADA;
                else                                    estado_d = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_d = INICIA_RODADA;
            FIM_ACERTOU:    estado_d = ctrl.iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_TIMEOUT:    estado_d = ctrl.iniciar ? PREPARACAO : FIM_TIMEOUT;
            FIM_ERROU:      estado_d = ctrl.iniciar ? PREPARACAO : FIM_ERROU;
            default:        estado_d = INICIAL;
        endcase
    end

    // Outputs depend on the present state only
    always_comb begin
        ctrl.zeraL     = 1'b0;
        ctrl.contaCL   = 1'b0;
        ctrl.zeraC     = 1'b0;
        ctrl.contaC    = 1'b0;
        ctrl.zeraR     = 1'b0;
        ctrl.registraR = 1'b0;
        ctrl.conta     = 1'b0;
        ctrl.pronto    = 1'b0;
        ctrl.acertou   = 1'b0;
        ctrl.errou     = 1'b0;
        ctrl.timeout   = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                ctrl.zeraL = 1'b1;
                ctrl.zeraC = 1'b1;
                ctrl.zeraR = 1'b1;
            end
            INICIA_RODADA: begin
                ctrl.zeraC = 1'b1;
                ctrl.zeraR = 1'b1;
            end
            ESPERA_JOGADA:  ctrl.conta     = 1'b1;
            REGISTRA:       ctrl.registraR = 1'b1;
            PROXIMA_JOGADA: ctrl.contaC    = 1'b1;
            PROXIMA_RODADA: ctrl.contaCL   = 1'b1;
            FIM_ACERTOU: begin
                ctrl.pronto  = 1'b1;
                ctrl.acertou = 1'b1;
            end
            FIM_TIMEOUT: begin
                ctrl.pronto  = 1'b1;
                ctrl.timeout = 1'b1;
            end
            FIM_ERROU: begin
                ctrl.pronto = 1'b1;
                ctrl.errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl.db_estado = estado_q;

endmodule

`default_nettype wire
